// File: rtl/riscv_pkg.sv
// Shared core types: the data-bus struct plus the data-memory access size
// and controller state encodings.
package riscv_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } dataBus_t;

  typedef enum logic [1:0] {
    MEM_B    = 2'b00,
    MEM_H    = 2'b01,
    MEM_W    = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_MAX_LATENCY = 8;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one data-memory access: write enables, write-data
// replication, read-data shift/zero-extend and misalignment detection.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [31:0] rshift;

  always_comb begin
    rshift       = rword_i >> {addr_lo_i, 3'b000};
    be_o         = 4'b0000;
    wdata_o      = wdata_i;
    rdata_o      = rword_i;
    misaligned_o = 1'b0;
    case (size_i)
      MEM_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'd0, rshift[7:0]};
      end
      MEM_H: begin
        misaligned_o = addr_lo_i[0];
        if (!addr_lo_i[0]) be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'd0, rshift[15:0]};
      end
      MEM_W: begin
        misaligned_o = (addr_lo_i != 2'b00);
        if (addr_lo_i == 2'b00) be_o = 4'b1111;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Tightly-coupled data-memory controller: owns the RAM, accepts one request
// per RD_LATENCY cycles and returns a registered, single-cycle response.
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int RD_LATENCY      = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_data_rd_en_ma,
  input  logic      i_data_wr_en_ma,
  input  logic [1:0] i_data_rd_en_ctrl,
  input  dataBus_t  i_data_addr,
  input  dataBus_t  i_data_wr,
  output logic      o_data_ready,
  output dataBus_t  o_data_rd,
  output logic      o_misaligned
);

  localparam int AW    = $clog2(MEM_DEPTH_WORDS);
  localparam int CNT_W = $clog2(DMEM_MAX_LATENCY);
  localparam logic [CNT_W-1:0] WAIT_INIT = (RD_LATENCY > 1) ? CNT_W'(RD_LATENCY - 2) : '0;

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             rvalid_q, rvalid_d;
  logic             mis_q, mis_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             op_rd_q, op_wr_q;
  mem_size_e        size_q;
  logic [AW+1:0]    addr_q;
  logic [31:0]      wdata_q;

  logic [31:0]      mem_q [MEM_DEPTH_WORDS];

  logic             take;
  logic             rsp_rd;
  mem_size_e        rsp_size;
  logic [AW+1:0]    rsp_addr;
  logic [31:0]      rsp_rdata;
  logic             rsp_mis;
  logic [31:0]      fwd_word;

  logic [3:0]       wr_be;
  logic [31:0]      wr_wrep;
  logic             wr_mis;
  logic             wr_commit;

  logic [3:0]       rsp_be_unused;
  logic [31:0]      rsp_wrep_unused;
  logic [31:0]      wr_rdata_unused;
  logic             unused_in;

  assign unused_in = ^{i_data_addr.valid, i_data_addr.data[31:AW+2], i_data_wr.valid};

  assign take      = ready_q & (i_data_rd_en_ma | i_data_wr_en_ma);
  assign wr_commit = (state_q == RESP) & op_wr_q & ~wr_mis;

  // With RD_LATENCY=1 the response is built from the request being accepted;
  // otherwise from the latched request when WAIT expires.
  always_comb begin
    if (take) begin
      rsp_rd   = i_data_rd_en_ma & ~i_data_wr_en_ma;
      rsp_size = mem_size_e'(i_data_rd_en_ctrl);
      rsp_addr = i_data_addr.data[AW+1:0];
    end else begin
      rsp_rd   = op_rd_q;
      rsp_size = size_q;
      rsp_addr = addr_q;
    end
  end

  // A read sampled at the edge that commits a write to the same word sees the new bytes.
  always_comb begin
    fwd_word = mem_q[rsp_addr[AW+1:2]];
    for (int l = 0; l < 4; l++) begin
      if (wr_commit && (addr_q[AW+1:2] == rsp_addr[AW+1:2]) && wr_be[l])
        fwd_word[8*l +: 8] = wr_wrep[8*l +: 8];
    end
  end

  dmem_lane_align u_rsp_lane (
    .size_i       (rsp_size),
    .addr_lo_i    (rsp_addr[1:0]),
    .wdata_i      (i_data_wr.data),
    .rword_i      (fwd_word),
    .be_o         (rsp_be_unused),
    .wdata_o      (rsp_wrep_unused),
    .rdata_o      (rsp_rdata),
    .misaligned_o (rsp_mis)
  );

  dmem_lane_align u_wr_lane (
    .size_i       (size_q),
    .addr_lo_i    (addr_q[1:0]),
    .wdata_i      (wdata_q),
    .rword_i      (32'd0),
    .be_o         (wr_be),
    .wdata_o      (wr_wrep),
    .rdata_o      (wr_rdata_unused),
    .misaligned_o (wr_mis)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (take) begin
          if (RD_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    ready_d  = (state_d != WAIT);
    mis_d    = (state_d == RESP) & rsp_mis;
    rvalid_d = (state_d == RESP) & rsp_rd & ~rsp_mis;
    rdata_d  = rvalid_d ? rsp_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      mis_q    <= mis_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      op_rd_q <= i_data_rd_en_ma & ~i_data_wr_en_ma;
      op_wr_q <= i_data_wr_en_ma;
      size_q  <= mem_size_e'(i_data_rd_en_ctrl);
      addr_q  <= i_data_addr.data[AW+1:0];
      wdata_q <= i_data_wr.data;
    end
  end

  // RAM is not reset; a write pending when reset hits never lands.
  always_ff @(posedge clk) begin
    if (rst_n && wr_commit) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be[l]) mem_q[addr_q[AW+1:2]][8*l +: 8] <= wr_wrep[8*l +: 8];
      end
    end
  end

  assign o_data_ready = ready_q;
  assign o_misaligned = mis_q;

  always_comb begin
    o_data_rd.valid = rvalid_q;
    o_data_rd.data  = rdata_q;
  end

endmodule
